// File: rtl/mem_bus_master_pkg.sv
// Shared definitions for the AddrData bus master and the memory controller.
// State encodings are plain constants so legacy blocks can share them.
package mem_bus_master_pkg;

  localparam int BURST_LEN_C = 4;
  localparam int DATA_W_C    = 16;

  typedef logic [2:0] bm_state_t;

  localparam bm_state_t BM_IDLE = 3'd0;
  localparam bm_state_t BM_ADDR = 3'd1;
  localparam bm_state_t BM_DATA = 3'd2;
  localparam bm_state_t BM_TURN = 3'd3;
  localparam bm_state_t BM_RESP = 3'd4;

endpackage

// File: rtl/mem_bus_master.sv
// CPU-side burst master for the multiplexed AddrData bus (address beat + BURST_LEN data beats).
// Optional MEM_BUS_MASTER_TURNAROUND_EN inserts one bus-idle TURN cycle before the response.
module mem_bus_master
  import mem_bus_master_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = DATA_W_C,
  parameter int BURST_LEN = BURST_LEN_C
) (
  input  logic                          clk,
  input  logic                          resetH,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_rw,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [BURST_LEN*DATA_W-1:0]   req_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_rw,
  output logic [BURST_LEN*DATA_W-1:0]   rsp_rdata,
  inout  tri   [DATA_W-1:0]             AddrData,
  output logic                          AddrValid,
  output logic                          rw
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  bm_state_t                      state;
  logic [BEAT_W-1:0]              beat;
  logic                           rw_lat;
  logic                           drive_en;
  logic [DATA_W-1:0]              drive_data;
  logic [BURST_LEN*DATA_W-1:0]    wdata_lat;
  logic [BURST_LEN*DATA_W-1:0]    rd_buf;
  logic [BURST_LEN*DATA_W-1:0]    rd_next;

  // Only registered state reaches the bus, so the driver never glitches or floats X.
  assign AddrData = drive_en ? drive_data : {DATA_W{1'bz}};
  assign rw       = rw_lat;
  assign rsp_rw   = rw_lat;

  always_comb begin
    rd_next = rd_buf;
    rd_next[int'(beat)*DATA_W +: DATA_W] = AddrData;
  end

  always_ff @(posedge clk or posedge resetH) begin
    if (resetH) begin
      state     <= BM_IDLE;
      beat      <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      AddrValid <= 1'b0;
      rw_lat    <= 1'b0;
      drive_en  <= 1'b0;
    end else begin
      case (state)
        BM_IDLE: begin
          if (req_valid && req_ready) begin
            state     <= BM_ADDR;
            req_ready <= 1'b0;
            rw_lat    <= req_rw;
            AddrValid <= 1'b1;
            drive_en  <= 1'b1;
          end
        end
        BM_ADDR: begin
          state     <= BM_DATA;
          beat      <= '0;
          AddrValid <= 1'b0;
          drive_en  <= !rw_lat;
        end
        BM_DATA: begin
          if (beat == LAST_BEAT) begin
            drive_en  <= 1'b0;
            rsp_rdata <= rw_lat ? rd_next : '0;
`ifdef MEM_BUS_MASTER_TURNAROUND_EN
            state     <= BM_TURN;
`else
            state     <= BM_RESP;
            rsp_valid <= 1'b1;
`endif
          end else begin
            beat <= beat + 1'b1;
          end
        end
`ifdef MEM_BUS_MASTER_TURNAROUND_EN
        BM_TURN: begin
          state     <= BM_RESP;
          rsp_valid <= 1'b1;
        end
`endif
        BM_RESP: begin
          if (rsp_ready) begin
            state     <= BM_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= BM_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          AddrValid <= 1'b0;
          drive_en  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath registers carry no reset; drive_en gates them off the bus.
  always_ff @(posedge clk) begin
    case (state)
      BM_IDLE: begin
        if (req_valid && req_ready) begin
          wdata_lat  <= req_wdata;
          drive_data <= DATA_W'(req_addr);
        end
      end
      BM_ADDR: begin
        drive_data <= wdata_lat[0 +: DATA_W];
      end
      BM_DATA: begin
        if (rw_lat) begin
          rd_buf <= rd_next;
        end
        if (beat != LAST_BEAT) begin
          drive_data <= wdata_lat[(int'(beat) + 1)*DATA_W +: DATA_W];
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// Scoreboard bench for mem_bus_master with a small memory-controller model on AddrData.
// Honours MEM_BUS_MASTER_TURNAROUND_EN for latency expectations.
module tb_mem_bus_master;
  import mem_bus_master_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int BL     = 4;
  localparam int WW     = BL*DATA_W;
`ifdef MEM_BUS_MASTER_TURNAROUND_EN
  localparam int TURN_C = 1;
`else
  localparam int TURN_C = 0;
`endif
  localparam int RSP_LAT = BL + 2 + TURN_C;

  logic              clk = 1'b0;
  logic              resetH;
  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [WW-1:0]     req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_rw;
  logic [WW-1:0]     rsp_rdata;
  tri0  [DATA_W-1:0] AddrData;
  logic              AddrValid;
  logic              rw;

  mem_bus_master dut (
    .clk(clk), .resetH(resetH),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rw(rsp_rw), .rsp_rdata(rsp_rdata),
    .AddrData(AddrData), .AddrValid(AddrValid), .rw(rw)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory controller model: stores write beats, returns read beats, wraps at 8 bits.
  logic [DATA_W-1:0] mem [256];
  logic              slv_en;
  logic [DATA_W-1:0] slv_data;
  logic              sact;
  logic              srw;
  logic [7:0]        sbase;
  logic [1:0]        sbeat;
  logic [7:0]        saddr;
  assign AddrData = slv_en ? slv_data : {DATA_W{1'bz}};
  assign saddr = sbase + {6'd0, sbeat};

  always @(posedge clk or posedge resetH) begin
    if (resetH) begin
      sact   <= 1'b0;
      slv_en <= 1'b0;
    end else if (AddrValid) begin
      sbase    <= AddrData[7:0];
      srw      <= rw;
      sbeat    <= 2'd0;
      sact     <= 1'b1;
      slv_en   <= rw;
      slv_data <= mem[AddrData[7:0]];
    end else if (sact) begin
      if (!srw) mem[saddr] <= AddrData;
      if (sbeat == 2'd3) begin
        sact   <= 1'b0;
        slv_en <= 1'b0;
      end else begin
        sbeat <= sbeat + 2'd1;
        if (srw) slv_data <= mem[8'(saddr + 8'd1)];
      end
    end
  end

  typedef struct { logic rw; logic [7:0] addr; logic [WW-1:0] words; int acc; } bus_exp_t;
  typedef struct { logic rw; logic [WW-1:0] rdata; int acc; } rsp_exp_t;
  bus_exp_t bus_q[$];
  rsp_exp_t rsp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus monitor
  bus_exp_t cur;
  logic     mact = 1'b0;
  int       mbeat = 0;
  always @(negedge clk) begin
    if (resetH) begin
      mact = 1'b0;
    end else if (AddrValid) begin
      if (bus_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_addrvalid: got AddrValid=1 expected no transaction at cycle %0d", cyc);
      end else begin
        cur = bus_q.pop_front();
        chk("addr_beat", 64'(AddrData), {56'd0, cur.addr});
        chk("addr_rw", 64'(rw), 64'(cur.rw));
        chk("addr_latency", 64'(cyc), 64'(cur.acc));
        mact  = 1'b1;
        mbeat = 0;
      end
    end else if (mact) begin
      chk(cur.rw ? "rd_beat" : "wr_beat", 64'(AddrData), 64'(cur.words[mbeat*DATA_W +: DATA_W]));
      mbeat++;
      if (mbeat == BL) mact = 1'b0;
    end
  end

  // Response monitor
  rsp_exp_t      re;
  logic          rseen = 1'b0;
  logic [WW-1:0] held;
  always @(negedge clk) begin
    if (resetH) begin
      rseen = 1'b0;
    end else if (rsp_valid) begin
      chk("req_ready_in_resp", 64'(req_ready), 64'd0);
      if (rsp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected none at cycle %0d", cyc);
      end else begin
        if (!rseen) begin
          chk("rsp_latency", 64'(cyc), 64'(rsp_q[0].acc + RSP_LAT - 1));
          held  = rsp_rdata;
          rseen = 1'b1;
        end else begin
          chk("rsp_hold_rdata", rsp_rdata, held);
        end
        if (rsp_ready) begin
          re = rsp_q.pop_front();
          chk("rsp_rw", 64'(rsp_rw), 64'(re.rw));
          chk("rsp_rdata", rsp_rdata, re.rdata);
          rseen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic r, input logic [7:0] a, input logic [WW-1:0] words,
                       input logic want_rsp, output int acc);
    int n = 0;
    bus_exp_t b;
    rsp_exp_t s;
    @(negedge clk);
    req_valid = 1'b1;
    req_rw    = r;
    req_addr  = a;
    req_wdata = r ? 64'h0 : words;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      errors++;
      checks++;
      $display("FAIL req_accept_timeout: got req_ready=0 expected 1 within 50 cycles");
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    b.rw = r; b.addr = a; b.words = words; b.acc = acc;
    bus_q.push_back(b);
    if (want_rsp) begin
      s.rw = r; s.rdata = r ? words : '0; s.acc = acc;
      rsp_q.push_back(s);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((rsp_q.size() != 0 || bus_q.size() != 0 || mact) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout: got %0d pending responses expected 0", rsp_q.size());
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    int a1, a2, n;
    resetH = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_addrvalid", 64'(AddrValid), 64'd0);
    chk("rst_rw", 64'(rw), 64'd0);
    chk("rst_bus_released", 64'(AddrData), 64'd0);
    resetH = 1'b0;

    // Write / read back at 0x10
    issue(1'b0, 8'h10, 64'h4444_3333_2222_1111, 1'b1, a1);
    drain();
    issue(1'b1, 8'h10, 64'h4444_3333_2222_1111, 1'b1, a1);
    drain();

    // Burst straddling the top of the address space
    issue(1'b0, 8'hFE, 64'hDDDD_CCCC_BBBB_AAAA, 1'b1, a1);
    drain();
    issue(1'b1, 8'hFE, 64'hDDDD_CCCC_BBBB_AAAA, 1'b1, a1);
    drain();

    // Response back-pressure with a competing request held
    rsp_ready = 1'b0;
    issue(1'b1, 8'h10, 64'h4444_3333_2222_1111, 1'b1, a1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_seen", 64'(rsp_valid), 64'd1);
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 8'h55; req_wdata = 64'h1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();

    // Reset during beat 2 of a write
    issue(1'b0, 8'h40, 64'h8888_7777_6666_5555, 1'b0, a1);
    n = 0;
    while (cyc != a1 + 3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    #2 resetH = 1'b1;
    #1;
    chk("midrst_bus_released", 64'(AddrData), 64'd0);
    chk("midrst_addrvalid", 64'(AddrValid), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    #2 resetH = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("postrst_no_rsp", 64'(rsp_valid), 64'd0);
      chk("postrst_req_ready", 64'(req_ready), 64'd1);
    end

    // Back-to-back reads
    issue(1'b1, 8'h10, 64'h4444_3333_2222_1111, 1'b1, a1);
    issue(1'b1, 8'hFE, 64'hDDDD_CCCC_BBBB_AAAA, 1'b1, a2);
    chk("b2b_spacing", 64'(a2 - a1), 64'(BL + 3 + TURN_C));
    drain();

    chk("bus_queue_empty", 64'(bus_q.size()), 64'd0);
    chk("rsp_queue_empty", 64'(rsp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
